// File: rtl/noc_pkg.sv
// Shared definitions for the ring NoC router output scheduler.
package noc_pkg;

    localparam logic [1:0] PORT_E = 2'd0;
    localparam logic [1:0] PORT_W = 2'd1;
    localparam logic [1:0] PORT_L = 2'd2;

    localparam int VALID_BIT = 0;

    typedef enum logic {
        IDLE,
        LOCK
    } state_t;

    function automatic logic [1:0] next_port(input logic [1:0] p);
        return (p == PORT_L) ? PORT_E : p + 2'd1;
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Rotating-priority picker over three requesters: searches ptr+1, ptr+2, ptr (mod 3).
module rr_pick3
    import noc_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic       found,
    output logic [1:0] idx
);

    logic [1:0] first_p;
    logic [1:0] second_p;

    assign first_p  = next_port(ptr);
    assign second_p = next_port(first_p);

    // Lowest priority assigned first so higher-priority hits overwrite it.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        if (req[ptr]) begin
            found = 1'b1;
            idx   = ptr;
        end
        if (req[second_p]) begin
            found = 1'b1;
            idx   = second_p;
        end
        if (req[first_p]) begin
            found = 1'b1;
            idx   = first_p;
        end
    end

endmodule

// File: rtl/noc_out_sched.sv
// Output-port scheduler: round-robin with packet lock, credit-gated registered link.
module noc_out_sched
    import noc_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CREDITS  = 32,
    parameter int TAIL_BIT = 15,
    localparam int CW      = $clog2(CREDITS + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         req,
    input  logic [3*WIDTH-1:0] req_data,
    output logic [2:0]         pop,
    input  logic               credit_ret,
    output logic [WIDTH-1:0]   dout,
    output logic               dout_valid,
    output logic [2:0]         grant,
    output logic [CW-1:0]      credits,
    output logic               credit_err
);

    state_t           state_q;
    logic [1:0]       rr_ptr_q;
    logic [1:0]       owner_q;
    logic [2:0]       grant_q;
    logic [CW-1:0]    credits_q;
    logic             err_q;
    logic [WIDTH-1:0] dout_q;
    logic             dvalid_q;

    logic             pick_found;
    logic [1:0]       pick_idx;
    logic [1:0]       sel;
    logic             sel_req;
    logic             do_pop;
    logic             send;
    logic [WIDTH-1:0] head;

    rr_pick3 u_pick (
        .req   (req),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        sel     = pick_idx;
        sel_req = pick_found;
        if (state_q == LOCK) begin
            sel     = owner_q;
            sel_req = req[owner_q];
        end
        case (sel)
            PORT_E:  head = req_data[0*WIDTH +: WIDTH];
            PORT_W:  head = req_data[1*WIDTH +: WIDTH];
            default: head = req_data[2*WIDTH +: WIDTH];
        endcase
        do_pop = reset_n && sel_req && (credits_q != '0);
        // Invalid heads are dequeued but never reach the link.
        send   = do_pop && head[VALID_BIT];
        pop    = do_pop ? (3'b001 << sel) : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            rr_ptr_q  <= PORT_L;
            owner_q   <= PORT_E;
            grant_q   <= '0;
            credits_q <= CW'(CREDITS);
            err_q     <= 1'b0;
            dout_q    <= '0;
            dvalid_q  <= 1'b0;
        end else begin
            dvalid_q <= send;
            if (send) begin
                dout_q <= head;
            end

            if (send && !credit_ret) begin
                credits_q <= credits_q - CW'(1);
            end else if (!send && credit_ret) begin
                if (credits_q == CW'(CREDITS)) begin
                    err_q <= 1'b1;
                end else begin
                    credits_q <= credits_q + CW'(1);
                end
            end

            case (state_q)
                IDLE: begin
                    if (send) begin
                        if (head[TAIL_BIT]) begin
                            rr_ptr_q <= sel;
                        end else begin
                            state_q <= LOCK;
                            owner_q <= sel;
                            grant_q <= 3'b001 << sel;
                        end
                    end
                end
                LOCK: begin
                    if (send && head[TAIL_BIT]) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= owner_q;
                        grant_q  <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dvalid_q;
    assign grant      = grant_q;
    assign credits    = credits_q;
    assign credit_err = err_q;

endmodule

// File: tb/tb_noc_out_sched.sv
// Directed self-checking bench for noc_out_sched (default and CREDITS=2 instances).
module tb_noc_out_sched;

    logic        clk = 1'b0;
    logic        reset_n;

    logic [2:0]  req;
    logic [47:0] req_data;
    logic [2:0]  pop;
    logic        credit_ret;
    logic [15:0] dout;
    logic        dout_valid;
    logic [2:0]  grant;
    logic [5:0]  credits;
    logic        credit_err;

    logic [2:0]  req2;
    logic [47:0] req_data2;
    logic [2:0]  pop2;
    logic        credit_ret2;
    logic [15:0] dout2;
    logic        dout_valid2;
    logic [2:0]  grant2;
    logic [1:0]  credits2;
    logic        credit_err2;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    noc_out_sched dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .req_data   (req_data),
        .pop        (pop),
        .credit_ret (credit_ret),
        .dout       (dout),
        .dout_valid (dout_valid),
        .grant      (grant),
        .credits    (credits),
        .credit_err (credit_err)
    );

    noc_out_sched #(.CREDITS(2)) dut2 (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req2),
        .req_data   (req_data2),
        .pop        (pop2),
        .credit_ret (credit_ret2),
        .dout       (dout2),
        .dout_valid (dout_valid2),
        .grant      (grant2),
        .credits    (credits2),
        .credit_err (credit_err2)
    );

    function automatic logic [15:0] mk(input logic tail, input logic valid, input logic [13:0] pl);
        return {tail, pl, valid};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        req         = 3'b111;
        req_data    = {mk(1, 1, 14'h1), mk(1, 1, 14'h2), mk(1, 1, 14'h3)};
        credit_ret  = 1'b0;
        req2        = 3'b000;
        req_data2   = '0;
        credit_ret2 = 1'b0;
        #1;
        total++; if (pop !== 3'b000) $display("FAIL reset_pop got %b want 000", pop); else pass_cnt++;
        step();
        total++; if (grant !== 3'b000) $display("FAIL reset_grant got %b want 000", grant); else pass_cnt++;
        total++; if (dout_valid !== 1'b0 || dout !== 16'h0) $display("FAIL reset_dout got v=%b d=%h want 0/0000", dout_valid, dout); else pass_cnt++;
        total++; if (credits !== 6'd32) $display("FAIL reset_credits got %0d want 32", credits); else pass_cnt++;
        total++; if (credit_err !== 1'b0) $display("FAIL reset_err got %b want 0", credit_err); else pass_cnt++;
        total++; if (credits2 !== 2'd2) $display("FAIL reset_credits2 got %0d want 2", credits2); else pass_cnt++;
        req     = 3'b000;
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_round_robin();
        logic [2:0]  exp_pop [4];
        logic [15:0] f [3];
        exp_pop = '{3'b001, 3'b010, 3'b100, 3'b001};
        f[0] = mk(1, 1, 14'h0E0);
        f[1] = mk(1, 1, 14'h0B1);
        f[2] = mk(1, 1, 14'h0C2);
        req_data = {f[2], f[1], f[0]};
        req      = 3'b111;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++; if (pop !== exp_pop[k]) $display("FAIL rr_pop%0d got %b want %b", k, pop, exp_pop[k]); else pass_cnt++;
            step();
            total++; if (dout_valid !== 1'b1 || dout !== f[k % 3]) $display("FAIL rr_dout%0d got v=%b d=%h want 1/%h", k, dout_valid, dout, f[k % 3]); else pass_cnt++;
            total++; if (credits !== 6'(31 - k)) $display("FAIL rr_credits%0d got %0d want %0d", k, credits, 31 - k); else pass_cnt++;
        end
        req = 3'b000;
        step();
        total++; if (dout_valid !== 1'b0 || dout !== f[0]) $display("FAIL rr_idle got v=%b d=%h want 0/%h", dout_valid, dout, f[0]); else pass_cnt++;
    endtask

    task automatic test_lock();
        logic [15:0] fe, fl, fw;
        fe  = mk(1, 1, 14'h101);
        fl  = mk(1, 1, 14'h303);
        req = 3'b111;
        for (int n = 0; n < 3; n++) begin
            fw       = mk(n == 2, 1, 14'(14'h200 + n));
            req_data = {fl, fw, fe};
            #1;
            total++; if (pop !== 3'b010) $display("FAIL lock_pop%0d got %b want 010", n, pop); else pass_cnt++;
            step();
            total++; if (grant !== ((n < 2) ? 3'b010 : 3'b000)) $display("FAIL lock_grant%0d got %b want %b", n, grant, (n < 2) ? 3'b010 : 3'b000); else pass_cnt++;
            total++; if (dout !== fw) $display("FAIL lock_dout%0d got %h want %h", n, dout, fw); else pass_cnt++;
        end
        #1;
        total++; if (pop !== 3'b100) $display("FAIL lock_next_pop got %b want 100", pop); else pass_cnt++;
        step();
        total++; if (credits !== 6'd24 || dout !== fl) $display("FAIL lock_after got c=%0d d=%h want 24/%h", credits, dout, fl); else pass_cnt++;
        req = 3'b000;
        step();
    endtask

    task automatic test_simul_sat();
        req_data   = {mk(1, 1, 14'h3), mk(1, 1, 14'h2), mk(1, 1, 14'h111)};
        req        = 3'b001;
        credit_ret = 1'b1;
        #1;
        total++; if (pop !== 3'b001) $display("FAIL simul_pop got %b want 001", pop); else pass_cnt++;
        step();
        total++; if (credits !== 6'd24) $display("FAIL simul_credits got %0d want 24", credits); else pass_cnt++;
        req = 3'b000;
        for (int k = 0; k < 8; k++) step();
        total++; if (credits !== 6'd32 || credit_err !== 1'b0) $display("FAIL refill got c=%0d e=%b want 32/0", credits, credit_err); else pass_cnt++;
        step();
        total++; if (credits !== 6'd32 || credit_err !== 1'b1) $display("FAIL saturate got c=%0d e=%b want 32/1", credits, credit_err); else pass_cnt++;
        credit_ret = 1'b0;
        step();
        step();
        total++; if (credit_err !== 1'b1) $display("FAIL err_sticky got %b want 1", credit_err); else pass_cnt++;
    endtask

    task automatic test_invalid();
        req_data = {mk(1, 1, 14'h3), mk(1, 1, 14'h2), mk(1, 0, 14'h0AA)};
        req      = 3'b001;
        #1;
        total++; if (pop !== 3'b001) $display("FAIL inv_pop got %b want 001", pop); else pass_cnt++;
        step();
        total++; if (dout_valid !== 1'b0) $display("FAIL inv_valid got %b want 0", dout_valid); else pass_cnt++;
        total++; if (credits !== 6'd32 || dout !== mk(1, 1, 14'h111)) $display("FAIL inv_hold got c=%0d d=%h want 32/%h", credits, dout, mk(1, 1, 14'h111)); else pass_cnt++;
        req = 3'b000;
        step();
    endtask

    task automatic test_exhaust();
        req2 = 3'b100;
        for (int k = 0; k < 2; k++) begin
            req_data2 = {mk(1, 1, 14'(14'h3C0 + k)), 32'h0};
            #1;
            total++; if (pop2 !== 3'b100) $display("FAIL exh_pop%0d got %b want 100", k, pop2); else pass_cnt++;
            step();
            total++; if (credits2 !== 2'(1 - k)) $display("FAIL exh_credits%0d got %0d want %0d", k, credits2, 1 - k); else pass_cnt++;
        end
        req_data2 = {mk(1, 1, 14'h3C2), 32'h0};
        for (int k = 0; k < 2; k++) begin
            #1;
            total++; if (pop2 !== 3'b000) $display("FAIL exh_stall%0d got %b want 000", k, pop2); else pass_cnt++;
            step();
        end
        credit_ret2 = 1'b1;
        #1;
        total++; if (pop2 !== 3'b000) $display("FAIL exh_ret_pop got %b want 000", pop2); else pass_cnt++;
        step();
        credit_ret2 = 1'b0;
        total++; if (credits2 !== 2'd1) $display("FAIL exh_ret_credits got %0d want 1", credits2); else pass_cnt++;
        #1;
        total++; if (pop2 !== 3'b100) $display("FAIL exh_resume_pop got %b want 100", pop2); else pass_cnt++;
        step();
        total++; if (credits2 !== 2'd0 || dout_valid2 !== 1'b1) $display("FAIL exh_resume got c=%0d v=%b want 0/1", credits2, dout_valid2); else pass_cnt++;
        #1;
        total++; if (pop2 !== 3'b000) $display("FAIL exh_final_pop got %b want 000", pop2); else pass_cnt++;
        req2 = 3'b000;
        step();
    endtask

    task automatic test_reset_mid();
        req_data = {mk(0, 1, 14'h3), mk(0, 1, 14'h2AA), mk(0, 1, 14'h1)};
        req      = 3'b010;
        #1;
        total++; if (pop !== 3'b010) $display("FAIL mid_pop got %b want 010", pop); else pass_cnt++;
        step();
        total++; if (grant !== 3'b010 || credits !== 6'd31) $display("FAIL mid_lock got g=%b c=%0d want 010/31", grant, credits); else pass_cnt++;
        #1;
        reset_n = 1'b0;
        #1;
        total++; if (grant !== 3'b000 || dout_valid !== 1'b0) $display("FAIL mid_reset got g=%b v=%b want 000/0", grant, dout_valid); else pass_cnt++;
        total++; if (credits !== 6'd32 || pop !== 3'b000) $display("FAIL mid_reset_cp got c=%0d p=%b want 32/000", credits, pop); else pass_cnt++;
        @(negedge clk);
        reset_n = 1'b1;
        req     = 3'b111;
        #1;
        total++; if (pop !== 3'b001) $display("FAIL mid_after_pop got %b want 001", pop); else pass_cnt++;
        step();
        total++; if (grant !== 3'b001) $display("FAIL mid_after_grant got %b want 001", grant); else pass_cnt++;
        req = 3'b000;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_round_robin();
        test_lock();
        test_simul_sat();
        test_invalid();
        test_exhaust();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/noc_out_sched.md
Name: noc_out_sched

Overview:
- Per-output-port scheduler for the ring NoC router.
- Shares one output link (E, W or L) between the three input FIFOs (E, W, L) using rotating round-robin priority.
- Holds the grant for the whole of a multi-flit packet, up to and including its tail flit.
- Gates sends on a credit counter that mirrors free space in the downstream FIFO, and drives a registered data/write pair onto the link.

Parameters:
WIDTH, 16, flit width; bit 0 is the valid flag
CREDITS, 32, downstream FIFO depth; credit counter reset value
TAIL_BIT, 15, flit bit that marks the last flit of a packet
CW, $clog2(CREDITS+1), credit counter width (derived)

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
req  input  3  per-requester FIFO non-empty (0=E, 1=W, 2=L)
req_data  input  3*WIDTH  FIFO head flits; requester i at [i*WIDTH +: WIDTH]
pop  output  3  one-hot dequeue strobe to the granted FIFO
credit_ret  input  1  one-cycle pulse: downstream freed one slot
dout  output  WIDTH  registered flit to the link
dout_valid  output  1  registered write strobe to downstream FIFO
grant  output  3  one-hot owner while a packet is locked; 0 in IDLE
credits  output  CW  current credit count
credit_err  output  1  sticky: credit returned while count already at CREDITS

Behaviour:
- Reset (reset_n low, asynchronous) forces:
  - state to IDLE and rr_ptr to 2, so E has first priority;
  - credits to CREDITS;
  - dout to 0, dout_valid to 0, grant to 0, credit_err to 0;
  - pop to 0 combinationally while reset_n is low.
- A send is possible when credits != 0. A credit_ret in the same cycle does not enable a send at credits == 0.
- States:
  - IDLE: candidate = first i with req[i]=1, searching i = rr_ptr+1, rr_ptr+2, rr_ptr (mod 3).
    - If a candidate exists and a send is possible: pop[candidate]=1 in this same cycle.
    - If the popped flit has TAIL_BIT=1: stay in IDLE and set rr_ptr=candidate.
    - Otherwise: go to LOCK, set owner=candidate, set grant=onehot(candidate).
  - LOCK: only the owner is served; req from the other requesters is ignored.
    - If req[owner]=1 and a send is possible: pop[owner]=1.
    - If that flit has TAIL_BIT=1: go to IDLE, set rr_ptr=owner, clear grant.
    - If req[owner]=0 or credits==0: stall (bubble) with no pop; stay in LOCK.
- pop is combinational from state, req, req_data and credits, and is at most one-hot.
- Data path:
  - On a pop cycle: the next edge loads dout from the popped flit and sets dout_valid=1.
  - Otherwise: dout_valid=0 on the next edge and dout holds its last value.
  - Latency from pop to dout_valid is 1 cycle.
- Credits update:
  - pop without credit_ret: credits -1.
  - credit_ret without pop: credits +1.
  - pop and credit_ret together: credits unchanged.
  - credit_ret with no pop while credits==CREDITS: count saturates and credit_err is set; it stays set until reset.
- Flits with bit 0 = 0 at the head of a requesting FIFO are popped and discarded. They do not consume a credit, do not assert dout_valid, and do not change state.
- Back-to-back single-flit packets from different requesters can be sent every cycle, with rotating order.
- Reset asserted mid-packet abandons the lock. Any partial packet downstream is not recovered.

Decomposition:
- Shared package noc_pkg holds:
  - port index constants PORT_E=0, PORT_W=1, PORT_L=2;
  - state enum {IDLE, LOCK};
  - VALID_BIT=0.
- One sub-module, rr_pick3: combinational rotating-priority picker.
  - Inputs: req[2:0], ptr[1:0].
  - Outputs: found, idx[1:0].
  - Instantiated for the IDLE pick.

Test Plan:
- Single-flit packets, round-robin order: after reset, all three req=1, every flit with tail and valid set, credits=32. Required: pop = 001, 010, 100, 001 on consecutive cycles; dout_valid high from cycle 2; credits counts 31, 30, 29, 28.
- Packet lock: W sends a 3-flit packet (tail on the 3rd flit) while E and L request throughout. Required: grant=010 for 3 pops; E and L are not popped until after the tail; the next grant goes to L (ptr=1, then search 2).
- Credit exhaustion: CREDITS=2, L streams 4 single-flit packets with no credit_ret. Required: 2 pops, then pop=0 with credits=0; a credit_ret pulse gives credits=1 and exactly one further pop in the following cycle.
- Simultaneous events and saturation: pop and credit_ret in the same cycle leave credits unchanged. Separately, credit_ret at credits=32 with no pop keeps credits at 32 and sets credit_err=1, which stays set.
- Invalid flit drop: E head flit has bit 0=0. Required: pop[0]=1 for one cycle, no dout_valid, credits unchanged.
- Reset mid-packet: reset_n pulsed low while in LOCK with owner W. Required: grant=000, dout_valid=0 and credits=32 immediately; after release the first grant goes to E.
